// File: rtl/caliptra_prim_xor_pkg.sv
// Shared types and tree-geometry helpers for the pipelined XOR reduction.
// Levels are packed back to back in one flat bus; these functions give sizes and offsets.
package caliptra_prim_xor_pkg;

  typedef enum logic {
    XorReduce = 1'b0,
    XorAccum  = 1'b1
  } xor_mode_e;

  // Entries present at tree level k (level 0 = raw operands).
  function automatic int unsigned num_level_entries(input int unsigned n, input int unsigned k);
    int unsigned e;
    e = n;
    for (int unsigned i = 0; i < k; i++) begin
      e = (e + 1) / 2;
    end
    return e;
  endfunction

  // Number of entries in all levels below k, i.e. the entry offset of level k in the flat bus.
  function automatic int unsigned level_entry_base(input int unsigned n, input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < k; i++) begin
      s = s + num_level_entries(n, i);
    end
    return s;
  endfunction

endpackage

// File: rtl/caliptra_prim_xor_reduce_pipe_if.sv
// Input-beat and result handshake bundle for the XOR reduction pipeline.
interface caliptra_prim_xor_reduce_pipe_if
  import caliptra_prim_xor_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned NumIn = 4
) ();

  logic                   valid_i;
  logic                   ready_o;
  logic [NumIn*Width-1:0] data_i;
  xor_mode_e              mode_i;
  logic                   clear_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [Width-1:0]       data_o;
  logic                   busy_o;

  modport master (
    output valid_i, data_i, mode_i, clear_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );

  modport slave (
    input  valid_i, data_i, mode_i, clear_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );

endinterface

// File: rtl/caliptra_prim_xor_tree_stage.sv
// One registered level of the XOR tree: pairwise XOR, odd entry passes through.
// xor_i is folded into entry 0 so the final level can merge the accumulator.
module caliptra_prim_xor_tree_stage
  import caliptra_prim_xor_pkg::*;
#(
  parameter  int unsigned Width      = 32,
  parameter  int unsigned NumEntries = 4,
  localparam int unsigned OutEntries = (NumEntries + 1) / 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        valid_i,
  input  xor_mode_e                   mode_i,
  input  logic [NumEntries*Width-1:0] data_i,
  input  logic [Width-1:0]            xor_i,
  output logic                        valid_o,
  output xor_mode_e                   mode_o,
  output logic [OutEntries*Width-1:0] data_o
);

  logic [OutEntries*Width-1:0] fold;
  logic [OutEntries*Width-1:0] data_d, data_q;
  logic                        vld_d, vld_q;
  xor_mode_e                   mode_d, mode_q;

  for (genvar j = 0; j < OutEntries; j++) begin : g_pair
    if (2 * j + 1 < NumEntries) begin : g_xor
      assign fold[j*Width +: Width] = data_i[(2*j)*Width +: Width] ^ data_i[(2*j+1)*Width +: Width];
    end else begin : g_pass
      assign fold[j*Width +: Width] = data_i[(2*j)*Width +: Width];
    end
  end

  // Payload only loads for real beats; a bubble just clears the valid.
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    data_d = data_q;
    if (en_i) begin
      vld_d = valid_i;
      if (valid_i) begin
        mode_d             = mode_i;
        data_d             = fold;
        data_d[Width-1:0]  = fold[Width-1:0] ^ xor_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      mode_q <= XorReduce;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign valid_o = vld_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/caliptra_prim_xor_reduce_pipe.sv
// Pipelined NumIn-operand XOR reduction with elastic valid/ready flow and an
// optional running-XOR accumulator merged at the last tree level.
module caliptra_prim_xor_reduce_pipe
  import caliptra_prim_xor_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned NumIn = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  caliptra_prim_xor_reduce_pipe_if.slave bus
);

  localparam int unsigned Stages  = $clog2(NumIn);
  localparam int unsigned BusE    = level_entry_base(NumIn, Stages + 1);
  localparam int unsigned LastIn  = level_entry_base(NumIn, Stages - 1) * Width;
  localparam int unsigned OutBase = level_entry_base(NumIn, Stages) * Width;

  logic [BusE*Width-1:0] lvl;
  logic [Stages:0]       vld;
  logic [Stages+1:1]     en;
  xor_mode_e             mode_l [Stages+1];

  logic [Width-1:0] acc_d, acc_q;
  logic [Width-1:0] acc_base, acc_inj, acc_fold;
  logic             acc_load;

  assign lvl[NumIn*Width-1:0] = bus.data_i;
  assign vld[0]               = bus.valid_i;
  assign mode_l[0]            = bus.mode_i;
  assign en[Stages+1]         = bus.ready_i;

  for (genvar k = 1; k <= Stages; k++) begin : g_level
    localparam int unsigned InE   = num_level_entries(NumIn, k - 1);
    localparam int unsigned OutE  = num_level_entries(NumIn, k);
    localparam int unsigned InOff = level_entry_base(NumIn, k - 1) * Width;
    localparam int unsigned OutOff = level_entry_base(NumIn, k) * Width;
    localparam bit          IsLast = (k == Stages);

    logic [Width-1:0] inj;

    // A level advances when it is empty or the level after it advances.
    assign en[k] = ~vld[k] | en[k+1];
    assign inj   = IsLast ? acc_inj : '0;

    caliptra_prim_xor_tree_stage #(
      .Width     (Width),
      .NumEntries(InE)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en[k]),
      .valid_i(vld[k-1]),
      .mode_i (mode_l[k-1]),
      .data_i (lvl[InOff +: InE*Width]),
      .xor_i  (inj),
      .valid_o(vld[k]),
      .mode_o (mode_l[k]),
      .data_o (lvl[OutOff +: OutE*Width])
    );
  end

  // Clear takes precedence over the stored value for a beat entering the output this cycle.
  assign acc_base = bus.clear_i ? '0 : acc_q;
  assign acc_inj  = (mode_l[Stages-1] == XorAccum) ? acc_base : '0;
  // The last level always folds exactly two entries.
  assign acc_fold = lvl[LastIn +: Width] ^ lvl[LastIn + Width +: Width] ^ acc_base;
  assign acc_load = en[Stages] & vld[Stages-1] & (mode_l[Stages-1] == XorAccum);

  always_comb begin
    acc_d = acc_base;
    if (acc_load) begin
      acc_d = acc_fold;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.ready_o = en[1];
  assign bus.valid_o = vld[Stages];
  assign bus.data_o  = lvl[OutBase +: Width];
  assign bus.busy_o  = |vld[Stages:1];

  // An accumulating beat leaves the accumulator equal to the result it produced.
  acc_tracks_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_load |=> (mode_l[Stages] == XorAccum) && (bus.data_o == acc_q));

endmodule

// File: tb/tb_caliptra_prim_xor_reduce_pipe.sv
// Randomised scoreboard bench for the XOR reduction pipeline at NumIn = 4, 3 and 2.
module tb_caliptra_prim_xor_reduce_pipe;
  import caliptra_prim_xor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  caliptra_prim_xor_reduce_pipe_if #(.Width(32), .NumIn(4)) if4 ();
  caliptra_prim_xor_reduce_pipe_if #(.Width(32), .NumIn(3)) if3 ();
  caliptra_prim_xor_reduce_pipe_if #(.Width(32), .NumIn(2)) if2 ();

  caliptra_prim_xor_reduce_pipe #(.Width(32), .NumIn(4)) u_dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(if4));
  caliptra_prim_xor_reduce_pipe #(.Width(32), .NumIn(3)) u_dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));
  caliptra_prim_xor_reduce_pipe #(.Width(32), .NumIn(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    bit          chk;
  } exp_t;

  exp_t        q4[$], q3[$], q2[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] acc_m [3];
  bit          chk_lat [3];
  bit          saw_low4 = 1'b0, done4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nin(input int d);
    return (d == 0) ? 4 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int stg(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q4.size() : (d == 1) ? q3.size() : q2.size();
  endfunction

  function automatic logic rdy_o(input int d);
    return (d == 0) ? if4.ready_o : (d == 1) ? if3.ready_o : if2.ready_o;
  endfunction

  function automatic logic busy(input int d);
    return (d == 0) ? if4.busy_o : (d == 1) ? if3.busy_o : if2.busy_o;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic xor_mode_e rmode();
    return ($urandom_range(0, 1) == 1) ? XorAccum : XorReduce;
  endfunction

  task automatic drive(input int d, input logic v, input logic [127:0] dat, input xor_mode_e m);
    case (d)
      0: begin if4.valid_i = v; if4.data_i = dat;       if4.mode_i = m; end
      1: begin if3.valid_i = v; if3.data_i = dat[95:0]; if3.mode_i = m; end
      default: begin if2.valid_i = v; if2.data_i = dat[63:0]; if2.mode_i = m; end
    endcase
  endtask

  // Reference: result is the XOR of every operand; ACCUM folds it into a running value.
  task automatic push(input int d, input logic [127:0] dat, input xor_mode_e m, input bit clr);
    logic [31:0] x;
    exp_t        e;
    x = '0;
    for (int k = 0; k < nin(d); k++) x ^= dat[k*32 +: 32];
    if (clr) acc_m[d] = '0;
    if (m == XorAccum) begin
      acc_m[d] ^= x;
      e.data = acc_m[d];
    end else begin
      e.data = x;
    end
    e.acc_cyc = cyc;
    e.chk     = chk_lat[d];
    case (d)
      0: q4.push_back(e);
      1: q3.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Offer one beat; clr pulses clear_i on dut4 in the cycle that beat enters the output register.
  task automatic send(input int d, input logic [127:0] dat, input xor_mode_e m, input bit clr);
    bit done;
    done = 1'b0;
    drive(d, 1'b1, dat, m);
    for (int w = 0; w < 64 && !done; w++) begin
      @(negedge clk);
      if (rdy_o(d)) begin
        push(d, dat, m, clr);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    drive(d, 1'b0, dat, m);
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL dut%0d_accept_timeout: ready_o stayed 0 for 64 cycles, required 1", d);
    end
    if (clr && d == 0) begin
      if4.clear_i = 1'b1;
      @(posedge clk); #1;
      if4.clear_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input int d);
    for (int w = 0; w < 200 && qsize(d) != 0; w++) @(posedge clk);
    #1;
    if (qsize(d) != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dut%0d_drain_timeout: %0d results outstanding, required 0", d, qsize(d));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("dut%0d_idle_busy", d), busy(d), 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [31:0] dat);
    exp_t e;
    if (!(rst_n && v && r)) return;
    if (qsize(d) == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dut%0d_unexpected: result 0x%08h presented, required none outstanding", d, dat);
      return;
    end
    case (d)
      0: e = q4.pop_front();
      1: e = q3.pop_front();
      default: e = q2.pop_front();
    endcase
    check($sformatf("dut%0d_data", d), dat, e.data);
    if (e.chk) check($sformatf("dut%0d_latency", d), 32'(cyc - e.acc_cyc), 32'(stg(d)));
  endtask

  initial begin : monitor
    bit          st;
    logic [31:0] st_d;
    st = 1'b0;
    st_d = '0;
    forever begin
      @(negedge clk);
      mon(0, if4.valid_o, if4.ready_i, if4.data_o);
      mon(1, if3.valid_o, if3.ready_i, if3.data_o);
      mon(2, if2.valid_o, if2.ready_i, if2.data_o);
      if (!rst_n) begin
        st = 1'b0;
      end else begin
        if (st) begin
          check("stall_valid_held", if4.valid_o, 1'b1);
          check("stall_data_held", if4.data_o, st_d);
        end
        st   = if4.valid_o && !if4.ready_i;
        st_d = if4.data_o;
        if (if4.valid_i && !if4.ready_o) saw_low4 = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    drive(0, 1'b0, '0, XorReduce);
    drive(1, 1'b0, '0, XorReduce);
    drive(2, 1'b0, '0, XorReduce);
    if4.clear_i = 1'b0; if3.clear_i = 1'b0; if2.clear_i = 1'b0;
    if4.ready_i = 1'b1; if3.ready_i = 1'b1; if2.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin acc_m[i] = '0; chk_lat[i] = 1'b0; end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid4", if4.valid_o, 1'b0);
    check("rst_busy4",  if4.busy_o,  1'b0);
    check("rst_data4",  if4.data_o,  32'h0);
    check("rst_valid3", if3.valid_o, 1'b0);
    check("rst_data3",  if3.data_o,  32'h0);
    check("rst_valid2", if2.valid_o, 1'b0);
    check("rst_busy2",  if2.busy_o,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain reduction, then a back-to-back burst at full throughput.
    chk_lat[0] = 1'b1;
    send(0, {32'h8, 32'h4, 32'h2, 32'h1}, XorReduce, 1'b0);
    for (int i = 0; i < 8; i++) send(0, rnd(), XorReduce, 1'b0);
    wait_drain(0);

    // Accumulate sequence with an interleaved reduce and both clear flavours.
    send(0, 128'hA, XorAccum, 1'b0);
    send(0, 128'h5, XorAccum, 1'b0);
    send(0, 128'hF, XorAccum, 1'b0);
    send(0, 128'h3, XorReduce, 1'b0);
    send(0, 128'hF, XorAccum, 1'b0);
    send(0, 128'h6, XorAccum, 1'b1);
    send(0, 128'h0, XorAccum, 1'b0);
    wait_drain(0);
    if4.clear_i = 1'b1;
    @(posedge clk); #1;
    if4.clear_i = 1'b0;
    acc_m[0] = '0;
    send(0, 128'h1, XorAccum, 1'b0);
    wait_drain(0);

    // Backpressure: output stalled while three beats are offered.
    chk_lat[0] = 1'b0;
    saw_low4 = 1'b0;
    if4.ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(0, rnd(), XorReduce, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_ready_low", if4.ready_o, 1'b0);
        check("bp_busy", if4.busy_o, 1'b1);
        @(posedge clk); #1;
        if4.ready_i = 1'b1;
      end
    join
    check("bp_saw_ready_low", saw_low4, 1'b1);
    wait_drain(0);

    // Random beats and modes under random output backpressure.
    done4 = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(0, rnd(), rmode(), 1'b0);
        done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(posedge clk); #1;
          if4.ready_i = ($urandom_range(0, 3) != 0);
        end
        if4.ready_i = 1'b1;
      end
    join
    wait_drain(0);

    // Non-power-of-two and minimum operand counts.
    chk_lat[1] = 1'b1;
    send(1, {32'h0, 32'hFF, 32'h0F, 32'hF0}, XorReduce, 1'b0);
    for (int i = 0; i < 6; i++) send(1, rnd(), rmode(), 1'b0);
    wait_drain(1);
    chk_lat[2] = 1'b1;
    send(2, {64'h0, 32'h5A, 32'hA5}, XorReduce, 1'b0);
    for (int i = 0; i < 6; i++) send(2, rnd(), rmode(), 1'b0);
    wait_drain(2);

    // Reset with two beats held in a stalled pipe.
    if4.ready_i = 1'b0;
    send(0, rnd(), XorAccum, 1'b0);
    send(0, rnd(), XorReduce, 1'b0);
    rst_n = 1'b0;
    q4.delete();
    for (int i = 0; i < 3; i++) acc_m[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", if4.valid_o, 1'b0);
    check("midrst_busy", if4.busy_o, 1'b0);
    check("midrst_data", if4.data_o, 32'h0);
    @(posedge clk); #1;
    if4.ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_lat[0] = 1'b1;
    send(0, 128'h1, XorAccum, 1'b0);
    wait_drain(0);

    check("queues_empty", 32'(q4.size() + q3.size() + q2.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
